// File: rtl/playseq_uc_vidas.sv
// PlaySeq control unit with lives, pause and optional LED preview.
// Moore FSM: every 1-bit control is a decode of the current state;
// latched difficulty, memory select, lives and fault cause are registers.
module playseq_uc_vidas #(
    parameter int NIVEL_W    = 2,
    parameter int MEM_W      = 2,
    parameter int VIDAS      = 3,
    parameter int VIDAS_W    = 2,
    parameter int PREVIEW_EN = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               jogar,
    input  logic               pausa,
    input  logic [NIVEL_W-1:0] nivel,
    input  logic [MEM_W-1:0]   memoria,
    input  logic               fimE,
    input  logic               igualS,
    input  logic               igualE,
    input  logic               tem_jogada,
    input  logic               timeout,
    input  logic               timeoutL,
    output logic               zeraE,
    output logic               contaE,
    output logic               carregaE,
    output logic               zeraS,
    output logic               contaS,
    output logic               zeraR,
    output logic               registraR,
    output logic               zeraT,
    output logic               contaT,
    output logic               zeraT_leds,
    output logic               contaT_leds,
    output logic               controla_leds,
    output logic               fase_preview,
    output logic               ganhou,
    output logic               perdeu,
    output logic               deu_timeout,
    output logic               pronto,
    output logic [NIVEL_W-1:0] nivel_uc,
    output logic [MEM_W-1:0]   memoria_uc,
    output logic [VIDAS_W-1:0] vidas,
    output logic [4:0]         db_estado
);

    typedef enum logic [4:0] {
        INICIAL       = 5'h00,
        PREPARACAO    = 5'h01,
        MOSTRA        = 5'h02,
        MOSTROU       = 5'h03,
        ESPERA_LED    = 5'h04,
        ZERA_TL       = 5'h05,
        INICIO_RODADA = 5'h06,
        ESPERA        = 5'h07,
        PAUSA         = 5'h08,
        REGISTRA      = 5'h09,
        COMPARA       = 5'h0A,
        PROXIMO       = 5'h0B,
        NOVA_SEQ      = 5'h0C,
        PERDE_VIDA    = 5'h0D,
        FIM_ACERTO    = 5'h0E,
        FIM_ERRO      = 5'h0F,
        FIM_TIMEOUT   = 5'h10
    } state_t;

    // Where every (re)played round begins: the preview, or straight to play.
    localparam state_t R_START = (PREVIEW_EN != 0) ? MOSTRA : INICIO_RODADA;

    state_t             r_estado;
    logic [VIDAS_W-1:0] r_vidas;
    logic               r_causa;   // 1 = last fault was a timeout
    logic [NIVEL_W-1:0] r_nivel;
    logic [MEM_W-1:0]   r_memoria;
    logic               w_legal;

    // State transitions plus the game registers updated alongside them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado  <= INICIAL;
            r_vidas   <= '0;
            r_causa   <= 1'b0;
            r_nivel   <= '0;
            r_memoria <= '0;
        end else begin
            case (r_estado)
                INICIAL:       if (jogar) r_estado <= PREPARACAO;
                PREPARACAO: begin
                    r_nivel   <= nivel;
                    r_memoria <= memoria;
                    r_vidas   <= VIDAS_W'(VIDAS);
                    r_causa   <= 1'b0;
                    r_estado  <= R_START;
                end
                MOSTRA:        if (timeoutL) r_estado <= igualS ? INICIO_RODADA : MOSTROU;
                MOSTROU:       r_estado <= ESPERA_LED;
                ESPERA_LED:    if (timeoutL) r_estado <= ZERA_TL;
                ZERA_TL:       r_estado <= MOSTRA;
                INICIO_RODADA: r_estado <= ESPERA;
                ESPERA: begin
                    // Timer expiry outranks a play arriving in the same cycle.
                    if (timeout) begin
                        r_causa  <= 1'b1;
                        r_estado <= PERDE_VIDA;
                    end else if (tem_jogada) begin
                        r_estado <= REGISTRA;
                    end else if (pausa) begin
                        r_estado <= PAUSA;
                    end
                end
                PAUSA:         if (!pausa) r_estado <= ESPERA;
                REGISTRA:      r_estado <= COMPARA;
                COMPARA: begin
                    if (!igualE) begin
                        r_causa  <= 1'b0;
                        r_estado <= PERDE_VIDA;
                    end else if (igualS && fimE) begin
                        r_estado <= FIM_ACERTO;
                    end else if (igualS) begin
                        r_estado <= NOVA_SEQ;
                    end else begin
                        r_estado <= PROXIMO;
                    end
                end
                PROXIMO:       r_estado <= ESPERA;
                NOVA_SEQ:      r_estado <= R_START;
                PERDE_VIDA: begin
                    // Last life (or none left) ends the game; otherwise replay the round.
                    if (r_vidas > VIDAS_W'(1)) begin
                        r_vidas  <= r_vidas - VIDAS_W'(1);
                        r_estado <= R_START;
                    end else begin
                        r_vidas  <= '0;
                        r_estado <= r_causa ? FIM_TIMEOUT : FIM_ERRO;
                    end
                end
                FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                               if (jogar) r_estado <= PREPARACAO;
                default:       r_estado <= INICIAL;
            endcase
        end
    end

    // Moore output decode of the current state.
    always_comb begin
        zeraE = 1'b0; contaE = 1'b0; carregaE = 1'b0;
        zeraS = 1'b0; contaS = 1'b0;
        zeraR = 1'b0; registraR = 1'b0;
        zeraT = 1'b0; contaT = 1'b0;
        zeraT_leds = 1'b0; contaT_leds = 1'b0;
        controla_leds = 1'b0; fase_preview = 1'b0;
        ganhou = 1'b0; perdeu = 1'b0; deu_timeout = 1'b0; pronto = 1'b0;
        w_legal = 1'b1;
        case (r_estado)
            INICIAL: begin
                zeraE = 1'b1; zeraS = 1'b1; zeraR = 1'b1; zeraT = 1'b1; zeraT_leds = 1'b1;
            end
            PREPARACAO: begin
                zeraE = 1'b1; carregaE = 1'b1; zeraS = 1'b1; zeraR = 1'b1;
                zeraT = 1'b1; zeraT_leds = 1'b1;
            end
            MOSTRA:        begin controla_leds = 1'b1; contaT_leds = 1'b1; fase_preview = 1'b1; end
            MOSTROU:       begin contaE = 1'b1; zeraT_leds = 1'b1; fase_preview = 1'b1; end
            ESPERA_LED:    contaT_leds = 1'b1;
            ZERA_TL:       begin zeraT_leds = 1'b1; fase_preview = 1'b1; end
            INICIO_RODADA: begin zeraE = 1'b1; zeraT = 1'b1; zeraT_leds = 1'b1; end
            ESPERA:        contaT = 1'b1;
            PAUSA:         ;
            REGISTRA:      registraR = 1'b1;
            COMPARA:       ;
            PROXIMO:       begin contaE = 1'b1; zeraT = 1'b1; end
            NOVA_SEQ:      begin contaS = 1'b1; zeraE = 1'b1; zeraT = 1'b1; zeraT_leds = 1'b1; end
            PERDE_VIDA:    begin zeraE = 1'b1; zeraT = 1'b1; zeraT_leds = 1'b1; end
            FIM_ACERTO:    begin pronto = 1'b1; ganhou = 1'b1; end
            FIM_ERRO:      begin pronto = 1'b1; perdeu = 1'b1; end
            FIM_TIMEOUT:   begin pronto = 1'b1; perdeu = 1'b1; deu_timeout = 1'b1; end
            default:       w_legal = 1'b0;
        endcase
    end

    assign db_estado  = w_legal ? r_estado : 5'h1F;
    assign nivel_uc   = r_nivel;
    assign memoria_uc = r_memoria;
    assign vidas      = r_vidas;

endmodule
